// File: rtl/cpu_pkg.sv
// Shared CPU defaults: address width, sequential increment and reset vector.
package cpu_pkg;

  localparam int unsigned N   = 32;
  localparam int unsigned INC = 4;

  typedef logic [N-1:0] addr_t;

  localparam addr_t RESET_PC = '0;

endpackage

// File: rtl/adder.sv
// Catalog adder: C = A + B, modulo 2^N.
module adder #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] C
);

  assign C = A + B;

endmodule

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// push and pop in the same cycle replace the top entry in place.
module ras_stack #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned N         = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(RAS_DEPTH);

  logic [N-1:0]  mem [RAS_DEPTH];
  logic [PW-1:0] tp;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_idx;

  assign top    = mem[tp];
  assign empty  = (cnt == '0);
  assign full   = (cnt == CMAX);
  // A plain push writes one slot above the top; a replace writes the top itself.
  assign wr_idx = pop ? tp : tp + PW'(1);

  // Top pointer wraps freely; count saturates at RAS_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      tp <= tp + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !push && !empty) begin
      tp  <= tp - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/program_counter.sv
// Program-counter register stage with a circular return-address stack.
// Optional target alignment check: define PC_ALIGN_CHECK_EN to add the
// 'misaligned' output and suppress branches/calls to targets not a multiple of INC.
module program_counter #(
  parameter int unsigned   N         = cpu_pkg::N,
  parameter logic [N-1:0]  RESET_PC  = N'(cpu_pkg::RESET_PC),
  parameter int unsigned   INC       = cpu_pkg::INC,
  parameter int unsigned   RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         branch_taken,
  input  logic         call,
  input  logic         ret,
  input  logic [N-1:0] branch_target,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus_inc,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ret_fault
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic         misaligned
`endif
);

  localparam logic [N-1:0] INC_V = N'(INC);

  logic [N-1:0] pc_next;
  logic [N-1:0] ras_top;
  logic         push;
  logic         pop;
  logic         fault_next;
  logic         target_ok;

  adder #(.N(N)) u_adder (
    .A (pc),
    .B (INC_V),
    .C (pc_plus_inc)
  );

  ras_stack #(.RAS_DEPTH(RAS_DEPTH), .N(N)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus_inc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [N-1:0] ALIGN_MASK = INC_V - N'(1);
  logic mis_next;

  assign target_ok = ((branch_target & ALIGN_MASK) == '0);
  // Only a call or a lone branch actually consumes the target.
  assign mis_next  = en && (call || (branch_taken && !ret)) && !target_ok;

  // One-cycle flag for a suppressed misaligned target.
  always_ff @(posedge clk) begin
    if (rst) misaligned <= 1'b0;
    else     misaligned <= mis_next;
  end
`else
  assign target_ok = 1'b1;
`endif

  // Next-PC selection and RAS control. call+ret folds into the call arm:
  // push together with pop replaces the top; with an empty RAS it is a plain push.
  always_comb begin
    pc_next    = pc_plus_inc;
    push       = 1'b0;
    pop        = 1'b0;
    fault_next = 1'b0;
    if (ret && !call) begin
      if (!ras_empty) begin
        pop     = en;
        pc_next = ras_top;
      end else begin
        fault_next = en;
      end
    end else if ((call || branch_taken) && target_ok) begin
      pc_next = branch_target;
      push    = en && call;
      pop     = en && call && ret && !ras_empty;
    end
  end

  // PC register and return-fault pulse; a stall holds pc and clears the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ret_fault <= 1'b0;
    end else begin
      if (en) pc <= pc_next;
      ret_fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a queue-based RAS model predicts each edge.
module tb_program_counter;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    addr_t pc;
    addr_t ppi;
    bit    empty;
    bit    full;
    bit    fault;
    bit    mis;
    string tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst, en, br, call, ret;
  addr_t tgt;
  addr_t pc, ppi;
  logic  ras_empty, ras_full, ret_fault;
  logic  rst2, en2;
  addr_t pc2, ppi2;
  logic  empty2, full2, fault2;
`ifdef PC_ALIGN_CHECK_EN
  logic  misaligned, misaligned2;
`endif

  exp_t  q[$];
  addr_t m_pc;
  addr_t m_ras[$];
  int    n_vec = 0;
  int    n_mis = 0;

  always #5 clk = ~clk;

  program_counter #(.N(32), .RESET_PC(32'h0), .INC(4), .RAS_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .en(en), .branch_taken(br), .call(call), .ret(ret),
    .branch_target(tgt), .pc(pc), .pc_plus_inc(ppi), .ras_empty(ras_empty),
    .ras_full(ras_full), .ret_fault(ret_fault)
`ifdef PC_ALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  program_counter #(.N(32), .RESET_PC(32'hFFFF_FFFC), .INC(4), .RAS_DEPTH(DEPTH)) u_dut_hi (
    .clk(clk), .rst(rst2), .en(en2), .branch_taken(1'b0), .call(1'b0), .ret(1'b0),
    .branch_target(32'h0), .pc(pc2), .pc_plus_inc(ppi2), .ras_empty(empty2),
    .ras_full(full2), .ret_fault(fault2)
`ifdef PC_ALIGN_CHECK_EN
    , .misaligned(misaligned2)
`endif
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic ras_push(input addr_t v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endtask

  // Drive one edge's inputs, advance the reference model and queue its prediction.
  task automatic step(input bit r, input bit e, input bit b, input bit c, input bit rt,
                      input addr_t t, input string tag);
    exp_t x;
    bit   ok;
    bit   fault = 1'b0;
    bit   mis   = 1'b0;
    @(negedge clk);
    rst = r; en = e; br = b; call = c; ret = rt; tgt = t;
    ok = !ALIGN || (t % 4 == 0);
    if (r) begin
      m_pc = 32'h0;
      m_ras.delete();
    end else if (e) begin
      if (rt && !c) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = m_pc + 4; fault = 1'b1; end
      end else if (c || b) begin
        if (!ok) begin
          m_pc = m_pc + 4;
          mis  = 1'b1;
        end else begin
          if (c && rt && m_ras.size() > 0) m_ras[m_ras.size() - 1] = m_pc + 4;
          else if (c) ras_push(m_pc + 4);
          m_pc = t;
        end
      end else begin
        m_pc = m_pc + 4;
      end
    end
    x.pc    = m_pc;
    x.ppi   = m_pc + 4;
    x.empty = (m_ras.size() == 0);
    x.full  = (m_ras.size() == DEPTH);
    x.fault = fault;
    x.mis   = mis;
    x.tag   = tag;
    q.push_back(x);
  endtask

  // Monitor: after every active edge, check the DUT against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin : chk
        exp_t x;
        x = q.pop_front();
        n_vec++;
        cmp({x.tag, " pc"}, pc, x.pc);
        cmp({x.tag, " pc_plus_inc"}, ppi, x.ppi);
        cmp({x.tag, " ras_empty"}, 32'(ras_empty), 32'(x.empty));
        cmp({x.tag, " ras_full"}, 32'(ras_full), 32'(x.full));
        cmp({x.tag, " ret_fault"}, 32'(ret_fault), 32'(x.fault));
`ifdef PC_ALIGN_CHECK_EN
        cmp({x.tag, " misaligned"}, 32'(misaligned), 32'(x.mis));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0; tgt = '0;
    rst2 = 1'b1; en2 = 1'b0;
    m_pc = '0;

    step(1, 0, 0, 0, 0, 32'h0, "reset");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0, "incr");
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, 32'h500, "stall");
    step(0, 1, 1, 0, 0, 32'h100, "branch");
    step(0, 1, 0, 0, 0, 32'h0, "after_branch");
    step(0, 1, 1, 0, 0, 32'h10, "goto_0x10");
    step(0, 1, 0, 1, 0, 32'h200, "call");
    step(0, 1, 0, 0, 0, 32'h0, "in_callee");
    step(0, 1, 0, 0, 1, 32'h0, "ret");
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 1, 0, addr_t'(i * 32'h1000), "nested_call");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 32'h0, "nested_ret");
    step(0, 1, 0, 0, 0, 32'h0, "fault_clear");
    step(0, 1, 0, 1, 0, 32'h300, "call_a");
    step(0, 1, 0, 1, 0, 32'h400, "call_b");
    step(1, 1, 0, 1, 0, 32'h500, "reset_with_ras");
    step(0, 1, 0, 1, 1, 32'h600, "callret_empty");
    step(0, 1, 0, 1, 1, 32'h700, "callret_replace");
    step(0, 1, 1, 0, 1, 32'h800, "branch_ret");
    step(0, 1, 1, 1, 0, 32'h900, "branch_call");
    step(0, 1, 1, 0, 0, 32'h102, "unaligned_target");
    step(0, 1, 0, 0, 0, 32'h0, "after_unaligned");
    step(0, 1, 1, 0, 0, 32'hFFFF_FFF8, "near_top");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0, "wrap");

    for (int i = 0; i < 400; i++) begin : rnd
      bit    r, e, b, c, rt;
      addr_t t;
      r  = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 99) < 85);
      b  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 3) == 0);
      t  = $urandom() & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0)  t = t | addr_t'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
      step(r, e, b, c, rt, t, "random");
    end

    @(negedge clk);
    en = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end

    // Reset vector at the top of the address space wraps to zero on the first advance.
    @(negedge clk);
    rst2 = 1'b1; en2 = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    cmp("hi_reset pc", pc2, 32'hFFFF_FFFC);
    cmp("hi_reset pc_plus_inc", ppi2, 32'h0);
    cmp("hi_reset ras_empty", 32'(empty2), 32'h1);
    cmp("hi_reset ras_full", 32'(full2), 32'h0);
    @(negedge clk);
    rst2 = 1'b0; en2 = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    cmp("hi_wrap pc", pc2, 32'h0);
    cmp("hi_wrap pc_plus_inc", ppi2, 32'h4);
    cmp("hi_wrap ret_fault", 32'(fault2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
